// File: rtl/alu_mux_pkg.sv
// Shared types and constants for the ALU operand/result select path.
// Select encoding names the four buses in input order.
package alu_mux_pkg;

    localparam int MUX_WIDTH = 4;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

endpackage

// File: rtl/mux4_comb.sv
// Combinational WIDTH-bit 4:1 select, no state.
// D doubles as the default arm so an unknown select cannot infer a latch.
module mux4_comb
    import alu_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  sel_e             sel_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = d_i;
        case (sel_i)
            SEL_A:   y_o = a_i;
            SEL_B:   y_o = b_i;
            SEL_C:   y_o = c_i;
            default: y_o = d_i;
        endcase
    end

endmodule

// File: rtl/four_bit_4_to_1_mux.sv
// Registered 4:1 bus select with a valid flag riding alongside Y.
// Y holds on idle cycles; out_valid tracks in_valid with one cycle of latency.
module four_bit_4_to_1_mux
    import alu_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [SEL_W-1:0] S,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             vld_d;
    logic             vld_q;

    mux4_comb #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a_i  (A),
        .b_i  (B),
        .c_i  (C),
        .d_i  (D),
        .sel_i(sel_e'(S)),
        .y_o  (sel_y)
    );

    always_comb begin
        y_d   = y_q;
        vld_d = 1'b0;
        if (in_valid) begin
            y_d   = sel_y;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_four_bit_4_to_1_mux.sv
// Scoreboard bench: stimulus pushes expected Y/out_valid, a monitor pops per cycle.
// Reference model indexes an array of the four buses by S.
module tb_four_bit_4_to_1_mux;

    typedef struct packed {
        logic [3:0] y;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = '0, B = '0, C = '0, D = '0;
    logic [1:0] S = '0;
    logic       in_valid = 1'b0;
    logic [3:0] Y;
    logic       out_valid;

    exp_t       q[$];
    logic [3:0] model_y = '0;
    int         errors = 0;
    int         checks = 0;

    four_bit_4_to_1_mux dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .S        (S),
        .in_valid (in_valid),
        .Y        (Y),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit v, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [1:0] s);
        logic [3:0] bus [4];
        exp_t       e;
        @(negedge clk);
        rst = r; in_valid = v;
        A = a; B = b; C = c; D = d; S = s;
        bus[0] = a; bus[1] = b; bus[2] = c; bus[3] = d;
        if (r) begin
            model_y = 4'd0;
            e = '{y: 4'd0, v: 1'b0};
        end else if (v) begin
            model_y = bus[s];
            e = '{y: model_y, v: 1'b1};
        end else begin
            e = '{y: model_y, v: 1'b0};
        end
        q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge after stimulus starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (Y !== e.y || out_valid !== e.v) begin
                    errors++;
                    $display("FAIL cyc%0d: Y=%b out_valid=%b expected Y=%b out_valid=%b",
                             checks, Y, out_valid, e.y, e.v);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with live inputs
        step(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        step(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        // Sweeps
        step(0, 1, 4'b0000, 4'b1000, 4'b0010, 4'b0100, 2'b00);
        step(0, 1, 4'b0001, 4'b1001, 4'b0011, 4'b0101, 2'b01);
        step(0, 1, 4'b0010, 4'b1010, 4'b0100, 4'b0110, 2'b10);
        step(0, 1, 4'b0011, 4'b1011, 4'b0101, 4'b0111, 2'b11);
        step(0, 1, 4'b0100, 4'b1100, 4'b0110, 4'b1000, 2'b00);
        step(0, 1, 4'b0101, 4'b1101, 4'b0111, 4'b1001, 2'b01);
        step(0, 1, 4'b0110, 4'b1110, 4'b1000, 4'b1010, 2'b10);
        step(0, 1, 4'b0111, 4'b1111, 4'b1001, 4'b1011, 2'b11);
        // Hold then reassert
        step(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        step(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        step(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        // Isolation: C selected, others toggling
        for (int i = 0; i < 10; i++)
            step(0, 1, 4'($urandom), 4'($urandom), 4'b0101,
                 4'($urandom), 2'b10);
        // Mid-stream reset between back-to-back valid words
        step(0, 1, 4'b1010, 4'b0011, 4'b1100, 4'b0110, 2'b00);
        step(1, 1, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 2'b01);
        step(0, 1, 4'b1001, 4'b0111, 4'b1100, 4'b0110, 2'b01);
        step(0, 1, 4'b1001, 4'b0111, 4'b1100, 4'b0110, 2'b11);
        // Randomised traffic with sparse resets and idle cycles
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 2'($urandom));
        step(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected pending=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
